// File: rtl/ans_ht_ltf_pkg.sv
// Shared types and limits for the HT-LTF sequencer.
// State encoding, symbol limits and the symbol-count clamp.
package ans_ht_ltf_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GRST,
    BOOT,
    WARM,
    REQ,
    STREAM,
    NEXT,
    FIN,
    ERR
  } state_t;

  localparam int SAMPLES_PER_SYM_DEF = 80;
  localparam int MAX_LTF = 4;

  function automatic logic [2:0] clamp_ltf(input logic [2:0] n);
    return (n > 3'(MAX_LTF)) ? 3'(MAX_LTF) : n;
  endfunction

endpackage

// File: rtl/ans_iq_negate.sv
// Per-component I/Q negation with saturation.
// The most negative value maps to the most positive one.
module ans_iq_negate (
  input  logic [31:0] din,
  input  logic        neg,
  output logic [31:0] dout
);

  function automatic logic [15:0] sneg(input logic [15:0] x);
    return (x == 16'h8000) ? 16'h7fff : (~x + 16'd1);
  endfunction

  assign dout = neg ? {sneg(din[31:16]), sneg(din[15:0])} : din;

endmodule

// File: rtl/ans_ht_ltf_sequencer.sv
// Drives the HT-LTF generator through reset, boot and warm-up,
// then streams each symbol out with its P-matrix sign applied.
module ans_ht_ltf_sequencer
  import ans_ht_ltf_pkg::*;
#(
  parameter int WARMUP_CYCLES   = 340,
  parameter int START_TIMEOUT   = 64,
  parameter int SAMPLES_PER_SYM = SAMPLES_PER_SYM_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   num_ltf,
  input  logic [3:0]   neg_mask,
  input  logic [127:0] obf_coeff_in,
  output logic         gen_reset,
  output logic         gen_letsgo,
  output logic         gen_givemeoutput,
  output logic [127:0] gen_obf_coeff,
  input  logic [31:0]  gen_ltf,
  input  logic         gen_started,
  output logic [31:0]  ltf_sample,
  output logic         ltf_valid,
  output logic         ltf_last,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam logic [15:0] WARM_LAST = 16'(WARMUP_CYCLES - 1);
  localparam logic [15:0] TO_LAST   = 16'(START_TIMEOUT - 1);
  localparam logic [15:0] SPS_LAST  = 16'(SAMPLES_PER_SYM - 1);
  localparam bit          ONE_SAMP  = (SAMPLES_PER_SYM == 1);

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  nsym;
  logic [1:0]  sym;
  logic [3:0]  mask;
  logic [31:0] neg_ltf;
  logic        cap;
  logic        cap_last;
  logic        final_sym;

  ans_iq_negate u_neg (
    .din  (gen_ltf),
    .neg  (mask[sym]),
    .dout (neg_ltf)
  );

  always_comb begin
    cap       = (state == REQ && gen_started) || state == STREAM;
    cap_last  = (state == STREAM) ? (cnt == SPS_LAST) : ONE_SAMP;
    final_sym = ({1'b0, sym} + 3'd1) == nsym;
  end

  // Generator strobes decode straight off the state register
  assign busy             = state != IDLE;
  assign gen_reset        = reset || state == GRST || state == ERR;
  assign gen_letsgo       = !reset && state == BOOT;
  assign gen_givemeoutput = !reset && (state == REQ || state == STREAM);
  assign done             = !reset && state == FIN;
  assign error            = !reset && state == ERR;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      nsym          <= '0;
      sym           <= '0;
      mask          <= '0;
      gen_obf_coeff <= '0;
      ltf_sample    <= '0;
      ltf_valid     <= 1'b0;
      ltf_last      <= 1'b0;
    end else begin
      ltf_valid <= cap;
      ltf_last  <= cap && cap_last && final_sym;
      if (cap) ltf_sample <= neg_ltf;
      unique case (state)
        IDLE: begin
          if (start) begin
            nsym          <= clamp_ltf(num_ltf);
            mask          <= neg_mask;
            gen_obf_coeff <= obf_coeff_in;
            sym           <= '0;
            cnt           <= '0;
            state         <= (num_ltf == 3'd0) ? FIN : GRST;
          end
        end
        GRST: state <= BOOT;
        BOOT: begin
          cnt   <= '0;
          state <= WARM;
        end
        WARM: begin
          if (cnt == WARM_LAST) begin
            cnt   <= '0;
            state <= REQ;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        REQ: begin
          if (gen_started) begin
            cnt   <= 16'd1;
            state <= ONE_SAMP ? NEXT : STREAM;
          end else if (cnt == TO_LAST) begin
            cnt   <= '0;
            state <= ERR;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STREAM: begin
          if (cnt == SPS_LAST) begin
            cnt   <= '0;
            state <= NEXT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        NEXT: begin
          sym   <= sym + 2'd1;
          state <= final_sym ? FIN : GRST;
        end
        FIN:     state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ans_ht_ltf_sequencer.sv
// Randomized bench for ans_ht_ltf_sequencer against a
// queue-based reference of the emitted sample stream.
module tb_ans_ht_ltf_sequencer;

  localparam int W   = 20;
  localparam int TO  = 64;
  localparam int SPS = 80;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   num_ltf = '0;
  logic [3:0]   neg_mask = '0;
  logic [127:0] obf_coeff_in = '0;
  logic         gen_reset;
  logic         gen_letsgo;
  logic         gen_givemeoutput;
  logic [127:0] gen_obf_coeff;
  logic [31:0]  gen_ltf = '0;
  logic         gen_started = 1'b0;
  logic [31:0]  ltf_sample;
  logic         ltf_valid;
  logic         ltf_last;
  logic         busy;
  logic         done;
  logic         error;

  ans_ht_ltf_sequencer #(
    .WARMUP_CYCLES   (W),
    .START_TIMEOUT   (TO),
    .SAMPLES_PER_SYM (SPS)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .num_ltf          (num_ltf),
    .neg_mask         (neg_mask),
    .obf_coeff_in     (obf_coeff_in),
    .gen_reset        (gen_reset),
    .gen_letsgo       (gen_letsgo),
    .gen_givemeoutput (gen_givemeoutput),
    .gen_obf_coeff    (gen_obf_coeff),
    .gen_ltf          (gen_ltf),
    .gen_started      (gen_started),
    .ltf_sample       (ltf_sample),
    .ltf_valid        (ltf_valid),
    .ltf_last         (ltf_last),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    bit          last;
  } exp_t;

  logic [31:0] pat [4][SPS];
  exp_t        q[$];

  int gdelay = 0;
  int gsym = -1;
  int gidx = 0;
  int gwait = 0;
  bit stray = 1'b1;

  int n_valid, n_done, n_err, n_lets, n_gmo, n_badlast, n_badgr;

  function automatic logic [15:0] ref_neg(input logic [15:0] x);
    int v;
    v = -int'($signed(x));
    if (v > 32767) v = 32767;
    return 16'(v);
  endfunction

  function automatic logic [31:0] ref_iq(input logic [31:0] x,
                                         input bit n);
    return n ? {ref_neg(x[31:16]), ref_neg(x[15:0])} : x;
  endfunction

  // Generator model: waits gdelay cycles after output enable
  always @(posedge clk) begin
    int gs;
    #1;
    if (gen_letsgo) gsym++;
    gs = (gsym < 0) ? 0 : gsym % 4;
    if (gen_reset) begin
      gidx = 0;
      gwait = gdelay;
      gen_started = 1'b0;
    end else if (gen_givemeoutput) begin
      if (gidx == 0) begin
        if (gwait == 0) begin
          gen_started = 1'b1;
          gen_ltf = pat[gs][0];
          gidx = 1;
        end else begin
          gwait--;
          gen_started = 1'b0;
          gen_ltf = $urandom;
        end
      end else begin
        gen_started = 1'b0;
        gen_ltf = (gidx < SPS) ? pat[gs][gidx] : $urandom;
        gidx++;
      end
    end else begin
      gen_started = stray && ($urandom_range(0, 5) == 0);
      gen_ltf = $urandom;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (ltf_valid) begin
        n_valid++;
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          chk("sample", 128'(ltf_sample), 128'(e.d));
          chk("last", 128'(ltf_last), 128'(e.last));
        end
      end
      if (ltf_last && !ltf_valid) n_badlast++;
      if (done) n_done++;
      if (error) begin
        n_err++;
        if (!gen_reset) n_badgr++;
      end
      if (gen_letsgo) n_lets++;
      if (gen_givemeoutput) n_gmo++;
    end
  end

  task automatic clr_counts();
    n_valid = 0; n_done = 0; n_err = 0; n_lets = 0;
    n_gmo = 0; n_badlast = 0; n_badgr = 0;
  endtask

  task automatic build_q(input int eff, input logic [3:0] m);
    q.delete();
    for (int s = 0; s < eff; s++)
      for (int i = 0; i < SPS; i++) begin
        exp_t e;
        e.d = ref_iq(pat[s][i], m[s]);
        e.last = (s == eff - 1) && (i == SPS - 1);
        q.push_back(e);
      end
  endtask

  task automatic fill_rand();
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < SPS; i++) begin
        pat[s][i] = $urandom;
        if ($urandom_range(0, 7) == 0) pat[s][i][31:16] = 16'h8000;
        if ($urandom_range(0, 7) == 0) pat[s][i][15:0] = 16'h8000;
      end
  endtask

  task automatic run_seq(input string tag, input int num,
                         input logic [3:0] m, input int dly,
                         input logic [127:0] cf, input bit exp_err);
    int eff;
    int t;
    eff = (num > 4) ? 4 : num;
    build_q(exp_err ? 0 : eff, m);
    clr_counts();
    gdelay = dly;
    gsym = -1;
    @(posedge clk); #1;
    start = 1'b1;
    num_ltf = 3'(num);
    neg_mask = m;
    obf_coeff_in = cf;
    @(posedge clk); #1;
    start = 1'b0;
    num_ltf = 3'($urandom);
    neg_mask = 4'($urandom);
    obf_coeff_in = {$urandom, $urandom, $urandom, $urandom};
    t = 0;
    while (n_done == 0 && n_err == 0 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_in_time"}, 128'(t < 20000), 128'(1));
    chk({tag, "_valids"}, 128'(n_valid), 128'(exp_err ? 0 : eff * SPS));
    chk({tag, "_done"}, 128'(n_done), 128'(exp_err ? 0 : 1));
    chk({tag, "_error"}, 128'(n_err), 128'(exp_err ? 1 : 0));
    chk({tag, "_letsgo"}, 128'(n_lets), 128'(exp_err ? 1 : eff));
    chk({tag, "_gmo_cycles"}, 128'(n_gmo),
        128'(exp_err ? TO : eff * (dly + SPS)));
    chk({tag, "_stray_last"}, 128'(n_badlast), 128'(0));
    chk({tag, "_err_genrst"}, 128'(n_badgr), 128'(0));
    chk({tag, "_q_left"}, 128'(q.size()), 128'(0));
    chk({tag, "_coeff"}, gen_obf_coeff, cf);
    chk({tag, "_idle"}, 128'(busy), 128'(0));
  endtask

  initial begin
    logic [127:0] ca;
    int t;
    clr_counts();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_genrst", 128'(gen_reset), 128'(1));
    chk("rst_valid", 128'(ltf_valid), 128'(0));
    chk("rst_sample", 128'(ltf_sample), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_coeff", gen_obf_coeff, 128'(0));
    chk("rst_gmo", 128'(gen_givemeoutput), 128'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_genrst", 128'(gen_reset), 128'(0));

    for (int i = 0; i < SPS; i++) pat[0][i] = 32'(i + 1);
    run_seq("one_sym", 1, 4'b0000, 3, {4{32'hA5A5_0001}}, 1'b0);

    for (int s = 0; s < 4; s++)
      for (int i = 0; i < SPS; i++) pat[s][i] = 32'h0001_FFFF;
    run_seq("four_sym", 4, 4'b0010, 0, {4{32'h1234_5678}}, 1'b0);

    for (int i = 0; i < SPS; i++) pat[0][i] = 32'h8000_8000;
    run_seq("sat", 1, 4'b0001, 5, {4{32'hDEAD_BEEF}}, 1'b0);

    fill_rand();
    run_seq("late_start", 2, 4'b0011, TO - 1, {4{32'h0F0F_0F0F}}, 1'b0);

    run_seq("timeout", 1, 4'b0000, 1000, {4{32'h5555_AAAA}}, 1'b1);
    run_seq("zero", 0, 4'b1111, 0, {4{32'h0000_0042}}, 1'b0);

    fill_rand();
    run_seq("seven", 7, 4'b1010, 2, {4{32'h7777_7777}}, 1'b0);

    for (int k = 0; k < 6; k++) begin
      fill_rand();
      run_seq("rand", int'($urandom_range(0, 7)), 4'($urandom),
              int'($urandom_range(0, 10)),
              {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    end

    // Abort mid-stream, with a second start while busy
    fill_rand();
    ca = {4{32'hCAFE_F00D}};
    build_q(2, 4'b0101);
    clr_counts();
    gdelay = 1;
    gsym = -1;
    @(posedge clk); #1;
    start = 1'b1; num_ltf = 3'd2; neg_mask = 4'b0101; obf_coeff_in = ca;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (n_valid < 30 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    chk("abort_reach_stream", 128'(t < 5000), 128'(1));
    #1;
    start = 1'b1; num_ltf = 3'd3; obf_coeff_in = ~ca;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("busy_start_ignored", gen_obf_coeff, ca);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_valid", 128'(ltf_valid), 128'(0));
    chk("abort_gmo", 128'(gen_givemeoutput), 128'(0));
    chk("abort_coeff", gen_obf_coeff, 128'(0));
    chk("abort_genrst", 128'(gen_reset), 128'(1));
    q.delete();
    reset = 1'b0;
    clr_counts();
    repeat (200) @(posedge clk);
    #1;
    chk("abort_no_valid", 128'(n_valid), 128'(0));
    chk("abort_no_done", 128'(n_done), 128'(0));
    chk("abort_no_error", 128'(n_err), 128'(0));
    chk("abort_no_lets", 128'(n_lets), 128'(0));
    chk("abort_still_idle", 128'(busy), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ans_ht_ltf_sequencer.md
ANS_HT_LTF_SEQUENCER -- requirements
Module: ans_ht_ltf_sequencer

Interface
REQ-001 The module SHALL have parameter WARMUP_CYCLES, default 340, meaning cycles from gen_letsgo to gen_givemeoutput.
REQ-002 The module SHALL have parameter START_TIMEOUT, default 64, meaning maximum cycles to wait for gen_started.
REQ-003 The module SHALL have parameter SAMPLES_PER_SYM, default 80, meaning samples per HT-LTF symbol.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to emit an HT-LTF sequence.
REQ-007 num_ltf  input  3  symbols to emit, sampled on accepted start.
REQ-008 neg_mask  input  4  bit k set: negate symbol k (P-matrix sign), sampled on accepted start.
REQ-009 obf_coeff_in  input  128  generator coefficients, sampled on accepted start.
REQ-010 gen_reset  output  1  reset pulse to the HT-LTF generator.
REQ-011 gen_letsgo  output  1  one-cycle boot pulse to the generator.
REQ-012 gen_givemeoutput  output  1  output enable to the generator.
REQ-013 gen_obf_coeff  output  128  latched coefficients to the generator.
REQ-014 gen_ltf  input  32  generator sample, {I[31:16], Q[15:0]}, two's complement.
REQ-015 gen_started  input  1  generator marks its first output sample.
REQ-016 ltf_sample  output  32  sequenced sample to the TX mux.
REQ-017 ltf_valid  output  1  ltf_sample valid.
REQ-018 ltf_last  output  1  final sample of the final symbol.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 done  output  1  one-cycle pulse on normal completion.
REQ-021 error  output  1  one-cycle pulse on start timeout.

Function
REQ-022 FSM states SHALL be IDLE, GRST, BOOT, WARM, REQ, STREAM, NEXT, FIN, ERR.
REQ-023 IDLE: start accepted -> latch inputs; effective count = min(num_ltf,4); count 0 -> FIN, else GRST.
REQ-024 start SHALL be ignored when not in IDLE.
REQ-025 GRST: gen_reset high exactly 1 cycle -> BOOT.
REQ-026 BOOT: gen_letsgo high exactly 1 cycle -> WARM.
REQ-027 WARM: counter runs WARMUP_CYCLES cycles -> REQ.
REQ-028 REQ: gen_givemeoutput high; gen_started -> STREAM with that cycle's gen_ltf as sample 0; START_TIMEOUT cycles without gen_started -> ERR.
REQ-029 STREAM: gen_givemeoutput high; samples 1..SAMPLES_PER_SYM-1 captured on consecutive cycles; after last capture gen_givemeoutput drops -> NEXT.
REQ-030 NEXT: symbol index increments; more symbols -> GRST, else FIN.
REQ-031 FIN: done pulse 1 cycle -> IDLE; ERR: error pulse 1 cycle, gen_reset high that cycle -> IDLE.
REQ-032 Output latency SHALL be exactly 1 cycle: captured sample appears on ltf_sample with ltf_valid the following cycle; no backpressure.
REQ-033 Negation SHALL apply per 16-bit component; -(-32768) SHALL saturate to 32767.
REQ-034 ltf_last SHALL coincide with ltf_valid of sample SAMPLES_PER_SYM-1 of the final symbol.
REQ-035 gen_started outside REQ SHALL be ignored.
REQ-036 gen_obf_coeff SHALL hold the latched value until the next accepted start.

Reset
REQ-037 reset SHALL force IDLE and zero all counters, ltf_sample, ltf_valid, ltf_last, done, error, gen_letsgo, gen_givemeoutput, gen_obf_coeff.
REQ-038 gen_reset SHALL be high while reset is high.
REQ-039 reset mid-sequence SHALL abort with no done, error or further ltf_valid.

Structure
REQ-040 Shared package ans_ht_ltf_pkg SHALL hold the state enum, SAMPLES_PER_SYM default and maximum symbol count (4).
REQ-041 Saturating component negation SHALL be sub-module ans_iq_negate.

Verification
REQ-042 num_ltf=1, neg_mask=0, generator model emits 80 samples 1..80 -> 80 ltf_valid cycles, samples unchanged, ltf_last on 80th, done once.
REQ-043 num_ltf=4, neg_mask=4'b0010, sample 32'h0001_FFFF -> symbol 1 emits 32'hFFFF_0001, others unchanged, 320 valids, 4 gen_letsgo pulses.
REQ-044 Negate sample 32'h8000_8000 -> output 32'h7FFF_7FFF.
REQ-045 gen_started withheld 64 cycles -> error pulse, no done, back to IDLE, gen_reset asserted.
REQ-046 num_ltf=0 -> done one cycle after FIN, zero gen_letsgo; num_ltf=7 -> exactly 4 symbols.
REQ-047 reset asserted mid-STREAM, start repeated while busy -> immediate IDLE, zero outputs, repeated start ignored.
